memory_port_arbiter: RTL and testbench
======================================

# memory_port_arbiter

Shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (loads/stores). Only one transaction is outstanding at a time. The block produces the pipeline-wide `stallControl` consumed by the hazard/trap logic, and discards fetch responses killed by a redirect or trap flush. It sits between the pipeline stages and the external memory handshake.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, data bus width
- `FAIR_LIMIT`, 4, consecutive data grants allowed while fetch waits (fairness build only)

- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `fetchRequest`  in  1  fetch wants an instruction word
- `fetchAddress`  in  ADDR_WIDTH  fetch PC
- `fetchKill`  in  1  flush of fetch path (branch redirect, trap, mret)
- `fetchReady`  out  1  one-cycle pulse: `fetchData` valid
- `fetchData`  out  DATA_WIDTH  instruction word
- `dataRequest`  in  1  memory stage access pending; held until `dataReady`
- `dataWrite`  in  1  1 = store, 0 = load
- `dataAddress`  in  ADDR_WIDTH  load/store address
- `dataWriteData`  in  DATA_WIDTH  store data
- `dataByteEnable`  in  4  store byte lanes
- `dataReady`  out  1  one-cycle pulse: access complete, `dataReadData` valid for loads
- `dataReadData`  out  DATA_WIDTH  load data
- `memRequest`  out  1  request to memory
- `memWrite`, `memAddress`, `memWriteData`, `memByteEnable`  out  1/ADDR_WIDTH/DATA_WIDTH/4  latched request fields
- `memAccept`  in  1  memory takes the request this cycle
- `memResponseValid`  in  1  read data / write ack this cycle
- `memReadData`  in  DATA_WIDTH  response data
- `stallControl`  out  1  freeze all pipeline registers

## Operation
- FSM states:
  - IDLE: arbitrate.
    - `dataRequest` → grant data.
    - Else `fetchRequest && !fetchKill` → grant fetch.
    - Else stay in IDLE.
    - On a grant: latch owner, address, write, data, byte enable; go to ISSUE.
  - ISSUE: `memRequest=1`, latched fields driven. On `memAccept` go to WAIT.
  - WAIT: on `memResponseValid`, pulse the owner's ready and go to IDLE.
- Ready pulses are combinational from `memResponseValid` in WAIT.
  - `fetchData`/`dataReadData` pass `memReadData` through.
  - Both ready outputs are 0 otherwise.
- Kill:
  - `fetchKill` while the owner is fetch in ISSUE or WAIT sets the `killed` flag.
  - The transaction still completes (a request cannot be withdrawn once issued).
  - `fetchReady` is suppressed for that response.
  - `killed` clears on entry to IDLE.
- `stallControl = dataRequest && !dataReady`. Fetch waits do not stall; the fetch stage bubbles until `fetchReady`.
- `memResponseValid` outside WAIT is ignored.
- Writes produce no data; `dataReady` marks the ack.

## Timing
- Reset values: state IDLE, `killed`=0, fairness counter 0.
- All outputs 0, including `memRequest`, `stallControl`, ready pulses and latched fields.
- Minimum latency, request seen in IDLE at cycle 0:
  - `memRequest` cycle 1.
  - Earliest `memAccept` cycle 1; response no earlier than the cycle after accept.
  - Ready pulse cycle 2 earliest.
  - Next grant decision cycle 3.
- `memRequest` and its fields are stable from ISSUE entry until `memAccept`.
- Simultaneous fetch and data request in IDLE: data wins.
- `fetchKill` in the same IDLE cycle as `fetchRequest`: no fetch grant.
- Reset mid-transaction: immediate return to IDLE. Any in-flight response arriving afterwards is ignored (not in WAIT).

## Configuration
- `MEMARB_FAIRNESS_EN` defined:
  - A counter increments on each data grant made while `fetchRequest` is high.
  - When the counter equals `FAIR_LIMIT` and `fetchRequest && !fetchKill`, the next IDLE grant goes to fetch even if `dataRequest` is high.
  - The counter clears on a fetch grant, or when `fetchRequest` is low in IDLE.
- `MEMARB_FAIRNESS_EN` undefined: strict data priority, no counter.

## Test plan
- Single fetch, addr 0x100, memory accepts cycle 1, responds 0x00000013 cycle 3 → `memRequest` cycles 1 only, `fetchReady` pulse cycle 3 with data 0x00000013, `stallControl` never high.
- Simultaneous `fetchRequest` and a load at 0x2000 → load issued first; `stallControl` high until its `dataReady`; fetch issued in the following IDLE cycle.
- Fetch in WAIT, `fetchKill` pulsed, response arrives 2 cycles later → no `fetchReady`; back to IDLE; next fetch at the new PC completes normally.
- Store 0xDEADBEEF, byte enable 0b0011, memory withholds `memAccept` 3 cycles → `memRequest` and fields held stable 4 cycles; `dataReady` on ack; `stallControl` high throughout until then.
- `reset` asserted in WAIT, then a stale `memResponseValid` → no ready pulses; all outputs 0 during reset.
- `MEMARB_FAIRNESS_EN` with `FAIR_LIMIT`=4: continuous loads plus continuous fetch → fetch granted after every 4th data grant; without the macro, fetch is never granted.

Source files
------------

// File: rtl/memory_port_arbiter.sv
// ============================================================================
// Module   : memory_port_arbiter
// Purpose  : Shares one memory port between instruction fetch and the memory
//            stage. One transaction is outstanding at a time. Data accesses
//            win arbitration. Fetch responses killed by a flush are dropped.
//            The block also drives the pipeline-wide stallControl.
// Options  : MEMARB_FAIRNESS_EN - when defined, fetch is forced a grant after
//            FAIR_LIMIT consecutive data grants made while fetch was waiting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FAIR_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    // fetch stage
    input  logic                  fetchRequest,
    input  logic [ADDR_WIDTH-1:0] fetchAddress,
    input  logic                  fetchKill,
    output logic                  fetchReady,
    output logic [DATA_WIDTH-1:0] fetchData,
    // memory stage
    input  logic                  dataRequest,
    input  logic                  dataWrite,
    input  logic [ADDR_WIDTH-1:0] dataAddress,
    input  logic [DATA_WIDTH-1:0] dataWriteData,
    input  logic [3:0]            dataByteEnable,
    output logic                  dataReady,
    output logic [DATA_WIDTH-1:0] dataReadData,
    // external memory
    output logic                  memRequest,
    output logic                  memWrite,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memWriteData,
    output logic [3:0]            memByteEnable,
    input  logic                  memAccept,
    input  logic                  memResponseValid,
    input  logic [DATA_WIDTH-1:0] memReadData,
    // pipeline control
    output logic                  stallControl
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_ownerData;
    logic                  r_killed;
    logic                  r_memRequest;
    logic                  r_memWrite;
    logic [ADDR_WIDTH-1:0] r_memAddress;
    logic [DATA_WIDTH-1:0] r_memWriteData;
    logic [3:0]            r_memByteEnable;

    logic w_fetchEligible;
    logic w_grantData;
    logic w_grantFetch;
    logic w_respInWait;

    assign w_fetchEligible = fetchRequest && !fetchKill;

`ifdef MEMARB_FAIRNESS_EN
    localparam int c_CNT_W = $clog2(FAIR_LIMIT + 1);

    logic [c_CNT_W-1:0] r_fairCount;
    logic               w_forceFetch;

    // Fetch is owed a turn once enough data grants have starved it.
    assign w_forceFetch = (r_fairCount == c_CNT_W'(FAIR_LIMIT)) && w_fetchEligible;
    assign w_grantData  = dataRequest && !w_forceFetch;
    assign w_grantFetch = !w_grantData && w_fetchEligible;

    // Count data grants made while fetch is waiting; saturates at the limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fairCount <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_grantFetch || !fetchRequest) begin
                r_fairCount <= '0;
            end else if (w_grantData && (r_fairCount != c_CNT_W'(FAIR_LIMIT))) begin
                r_fairCount <= r_fairCount + c_CNT_W'(1);
            end
        end
    end
`else
    assign w_grantData  = dataRequest;
    assign w_grantFetch = !dataRequest && w_fetchEligible;
`endif

    // Transaction sequencer: arbitrate, hold the request until accepted, then
    // wait for the single response.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_ownerData     <= 1'b0;
            r_killed        <= 1'b0;
            r_memRequest    <= 1'b0;
            r_memWrite      <= 1'b0;
            r_memAddress    <= '0;
            r_memWriteData  <= '0;
            r_memByteEnable <= 4'b0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_killed <= 1'b0;
                    if (w_grantData) begin
                        r_ownerData     <= 1'b1;
                        r_memRequest    <= 1'b1;
                        r_memWrite      <= dataWrite;
                        r_memAddress    <= dataAddress;
                        r_memWriteData  <= dataWriteData;
                        r_memByteEnable <= dataByteEnable;
                        r_state         <= ST_ISSUE;
                    end else if (w_grantFetch) begin
                        // Instruction fetch is always a full-word read.
                        r_ownerData     <= 1'b0;
                        r_memRequest    <= 1'b1;
                        r_memWrite      <= 1'b0;
                        r_memAddress    <= fetchAddress;
                        r_memWriteData  <= '0;
                        r_memByteEnable <= 4'b1111;
                        r_state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (fetchKill && !r_ownerData) begin
                        r_killed <= 1'b1;
                    end
                    if (memAccept) begin
                        r_memRequest <= 1'b0;
                        r_state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (memResponseValid) begin
                        r_killed <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (fetchKill && !r_ownerData) begin
                        r_killed <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_memRequest <= 1'b0;
                end
            endcase
        end
    end

    // A response only counts in WAIT; reset masks everything immediately,
    // including a response still arriving from the transaction being dropped.
    assign w_respInWait = !reset && (r_state == ST_WAIT) && memResponseValid;

    // A kill arriving with the response itself also drops that response.
    assign fetchReady   = w_respInWait && !r_ownerData && !r_killed && !fetchKill;
    assign dataReady    = w_respInWait && r_ownerData;
    assign fetchData    = (!reset && r_state == ST_WAIT) ? memReadData : '0;
    assign dataReadData = (!reset && r_state == ST_WAIT) ? memReadData : '0;

    assign stallControl = !reset && dataRequest && !dataReady;

    assign memRequest    = r_memRequest && !reset;
    assign memWrite      = r_memWrite && !reset;
    assign memAddress    = reset ? '0 : r_memAddress;
    assign memWriteData  = reset ? '0 : r_memWriteData;
    assign memByteEnable = reset ? 4'b0000 : r_memByteEnable;

endmodule

`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
// ============================================================================
// Module   : tb_memory_port_arbiter
// Purpose  : Self-checking bench for memory_port_arbiter. A transaction-level
//            model predicts every output each cycle; directed scenarios pin
//            literal values; a randomized phase stresses arbitration, kills,
//            memory back-pressure and reset.
// Options  : MEMARB_FAIRNESS_EN - must match the build of the design.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_port_arbiter;

    localparam int c_FAIR_LIMIT = 4;
`ifdef MEMARB_FAIRNESS_EN
    localparam bit c_FAIR_ON = 1'b1;
`else
    localparam bit c_FAIR_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        fetchRequest;
    logic [31:0] fetchAddress;
    logic        fetchKill;
    logic        fetchReady;
    logic [31:0] fetchData;
    logic        dataRequest;
    logic        dataWrite;
    logic [31:0] dataAddress;
    logic [31:0] dataWriteData;
    logic [3:0]  dataByteEnable;
    logic        dataReady;
    logic [31:0] dataReadData;
    logic        memRequest;
    logic        memWrite;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic [3:0]  memByteEnable;
    logic        memAccept;
    logic        memResponseValid;
    logic [31:0] memReadData;
    logic        stallControl;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    memory_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .FAIR_LIMIT(c_FAIR_LIMIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .fetchRequest(fetchRequest),
        .fetchAddress(fetchAddress),
        .fetchKill(fetchKill),
        .fetchReady(fetchReady),
        .fetchData(fetchData),
        .dataRequest(dataRequest),
        .dataWrite(dataWrite),
        .dataAddress(dataAddress),
        .dataWriteData(dataWriteData),
        .dataByteEnable(dataByteEnable),
        .dataReady(dataReady),
        .dataReadData(dataReadData),
        .memRequest(memRequest),
        .memWrite(memWrite),
        .memAddress(memAddress),
        .memWriteData(memWriteData),
        .memByteEnable(memByteEnable),
        .memAccept(memAccept),
        .memResponseValid(memResponseValid),
        .memReadData(memReadData),
        .stallControl(stallControl)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference: at most one outstanding transaction,
    // described by who owns it, its latched fields, whether memory has
    // taken it yet and whether its fetch result has been flushed.
    // ------------------------------------------------------------------
    bit          mActive    = 1'b0;
    bit          mOwnerData = 1'b0;
    bit          mAccepted  = 1'b0;
    bit          mKilled    = 1'b0;
    int          mCnt       = 0;
    logic        mWrite     = 1'b0;
    logic [31:0] mAddr      = '0;
    logic [31:0] mWdata     = '0;
    logic [3:0]  mBe        = '0;
    bit          sawDataReady = 1'b0;

    always @(negedge clock) begin
        bit          eMR, eFR, eDR, eSt, resp, fetchOk, forceF;
        logic        eWr;
        logic [31:0] eAd, eWd;
        logic [3:0]  eBe;
        if (reset) begin
            eMR = 0; eFR = 0; eDR = 0; eSt = 0;
            eWr = 0; eAd = '0; eWd = '0; eBe = '0;
        end else begin
            eMR  = mActive && !mAccepted;
            eWr  = mWrite; eAd = mAddr; eWd = mWdata; eBe = mBe;
            resp = mActive && mAccepted && memResponseValid;
            eFR  = resp && !mOwnerData && !mKilled && !fetchKill;
            eDR  = resp && mOwnerData;
            eSt  = dataRequest && !eDR;
        end
        chk("memRequest",    memRequest,    eMR);
        chk("memWrite",      memWrite,      eWr);
        chk("memAddress",    memAddress,    eAd);
        chk("memWriteData",  memWriteData,  eWd);
        chk("memByteEnable", memByteEnable, eBe);
        chk("fetchReady",    fetchReady,    eFR);
        chk("dataReady",     dataReady,     eDR);
        chk("stallControl",  stallControl,  eSt);
        if (eFR) chk("fetchData", fetchData, memReadData);
        if (eDR && !mWrite) chk("dataReadData", dataReadData, memReadData);
        sawDataReady = eDR;

        // advance the model across the coming rising edge
        if (reset) begin
            mActive = 0; mAccepted = 0; mKilled = 0; mCnt = 0; mOwnerData = 0;
            mWrite = 0; mAddr = '0; mWdata = '0; mBe = '0;
        end else if (!mActive) begin
            fetchOk = fetchRequest && !fetchKill;
            forceF  = c_FAIR_ON && (mCnt == c_FAIR_LIMIT) && fetchOk;
            if (dataRequest && !forceF) begin
                mActive = 1; mAccepted = 0; mKilled = 0; mOwnerData = 1;
                mWrite = dataWrite; mAddr = dataAddress; mWdata = dataWriteData; mBe = dataByteEnable;
                mCnt = fetchRequest ? ((mCnt < c_FAIR_LIMIT) ? mCnt + 1 : mCnt) : 0;
            end else if (fetchOk) begin
                mActive = 1; mAccepted = 0; mKilled = 0; mOwnerData = 0;
                mWrite = 0; mAddr = fetchAddress; mWdata = '0; mBe = 4'hF;
                mCnt = 0;
            end else if (!fetchRequest) begin
                mCnt = 0;
            end
        end else if (!mAccepted) begin
            if (!mOwnerData && fetchKill) mKilled = 1;
            if (memAccept) mAccepted = 1;
        end else begin
            if (memResponseValid) begin
                mActive = 0; mKilled = 0;
            end else if (!mOwnerData && fetchKill) begin
                mKilled = 1;
            end
        end
    end

    task automatic go();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic idleInputs();
        fetchRequest = 0; fetchAddress = '0; fetchKill = 0;
        dataRequest = 0; dataWrite = 0; dataAddress = '0; dataWriteData = '0; dataByteEnable = '0;
        memAccept = 0; memResponseValid = 0; memReadData = '0;
    endtask

    initial begin
        int nf, nd, expF;
        reset = 1;
        idleInputs();
        dataRequest = 1;
        go(); go(); go();
        smp();
        chk("rst_memRequest", memRequest, 1'b0);
        chk("rst_stall", stallControl, 1'b0);
        chk("rst_memAddress", memAddress, 32'h0);

        // single fetch at 0x100
        go(); reset = 0; idleInputs();
        go(); fetchRequest = 1; fetchAddress = 32'h100;
        smp(); chk("f1_c0_memRequest", memRequest, 1'b0);
        go(); fetchRequest = 0; memAccept = 1;
        smp(); chk("f1_c1_memRequest", memRequest, 1'b1);
        chk("f1_c1_memAddress", memAddress, 32'h100);
        go(); memAccept = 0;
        smp(); chk("f1_c2_memRequest", memRequest, 1'b0);
        go(); memResponseValid = 1; memReadData = 32'h0000_0013;
        smp(); chk("f1_c3_fetchReady", fetchReady, 1'b1);
        chk("f1_c3_fetchData", fetchData, 32'h0000_0013);
        chk("f1_c3_stall", stallControl, 1'b0);
        go(); memResponseValid = 0;
        smp(); chk("f1_c4_fetchReady", fetchReady, 1'b0);

        // simultaneous fetch and load: load first
        go(); fetchRequest = 1; fetchAddress = 32'h104;
        dataRequest = 1; dataWrite = 0; dataAddress = 32'h2000;
        smp(); chk("sim_c0_stall", stallControl, 1'b1);
        go(); memAccept = 1;
        smp(); chk("sim_c1_memAddress", memAddress, 32'h2000);
        chk("sim_c1_stall", stallControl, 1'b1);
        go(); memAccept = 0; memResponseValid = 1; memReadData = 32'h55;
        smp(); chk("sim_c2_dataReady", dataReady, 1'b1);
        chk("sim_c2_dataReadData", dataReadData, 32'h55);
        chk("sim_c2_stall", stallControl, 1'b0);
        go(); memResponseValid = 0; dataRequest = 0;
        go(); fetchRequest = 0; memAccept = 1;
        smp(); chk("sim_c4_memAddress", memAddress, 32'h104);
        go(); memAccept = 0; memResponseValid = 1; memReadData = 32'h77;
        smp(); chk("sim_c5_fetchReady", fetchReady, 1'b1);
        go(); memResponseValid = 0;

        // store with accept withheld for three cycles
        go(); dataRequest = 1; dataWrite = 1; dataAddress = 32'h40;
        dataWriteData = 32'hDEAD_BEEF; dataByteEnable = 4'b0011;
        smp(); chk("st_c0_stall", stallControl, 1'b1);
        for (int k = 0; k < 3; k++) begin
            go();
            smp(); chk("st_hold_memRequest", memRequest, 1'b1);
            chk("st_hold_wdata", memWriteData, 32'hDEAD_BEEF);
            chk("st_hold_be", memByteEnable, 4'b0011);
        end
        go(); memAccept = 1;
        smp(); chk("st_c4_memRequest", memRequest, 1'b1);
        go(); memAccept = 0; memResponseValid = 1;
        smp(); chk("st_c5_dataReady", dataReady, 1'b1);
        chk("st_c5_stall", stallControl, 1'b0);
        go(); memResponseValid = 0; dataRequest = 0; dataWrite = 0;

        // kill while waiting, then fetch at the new PC
        go(); fetchRequest = 1; fetchAddress = 32'h200;
        go(); fetchRequest = 0; memAccept = 1;
        go(); memAccept = 0; fetchKill = 1;
        go(); fetchKill = 0;
        go(); memResponseValid = 1; memReadData = 32'h1111;
        smp(); chk("kill_fetchReady", fetchReady, 1'b0);
        go(); memResponseValid = 0; fetchRequest = 1; fetchAddress = 32'h300;
        go(); fetchRequest = 0; memAccept = 1;
        smp(); chk("kill_newpc_addr", memAddress, 32'h300);
        go(); memAccept = 0; memResponseValid = 1; memReadData = 32'hABC;
        smp(); chk("kill_newpc_ready", fetchReady, 1'b1);
        go(); memResponseValid = 0;

        // reset while waiting, stale response afterwards
        go(); fetchRequest = 1; fetchAddress = 32'h500;
        go(); fetchRequest = 0; memAccept = 1;
        go(); memAccept = 0; reset = 1; dataRequest = 1; memResponseValid = 1;
        smp(); chk("rw_memRequest", memRequest, 1'b0);
        chk("rw_fetchReady", fetchReady, 1'b0);
        chk("rw_stall", stallControl, 1'b0);
        go(); reset = 0; dataRequest = 0; memResponseValid = 1;
        smp(); chk("rw_stale_fetchReady", fetchReady, 1'b0);
        chk("rw_stale_dataReady", dataReady, 1'b0);
        go(); idleInputs();

        // continuous loads and fetch: 15 back-to-back transactions
        go(); fetchRequest = 1; fetchAddress = 32'h600; dataRequest = 1;
        dataAddress = 32'h3000; memAccept = 1; memResponseValid = 1; memReadData = 32'h9;
        nf = 0; nd = 0;
        for (int c = 0; c < 45; c++) begin
            smp();
            nf += fetchReady ? 1 : 0;
            nd += dataReady ? 1 : 0;
            if (c < 44) go();
        end
        expF = c_FAIR_ON ? 3 : 0;
        chk("fair_fetch_grants", nf, expF);
        chk("fair_data_grants", nd, 15 - expF);
        go(); idleInputs();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            go();
            reset            = ($urandom_range(99) == 0);
            memAccept        = $urandom_range(1) == 1;
            memResponseValid = ($urandom_range(2) == 0);
            memReadData      = $urandom;
            fetchRequest     = ($urandom_range(9) < 7);
            fetchAddress     = $urandom & 32'hFFFF_FFFC;
            fetchKill        = ($urandom_range(9) == 0);
            if (!dataRequest || sawDataReady) begin
                dataRequest    = ($urandom_range(9) < 4);
                dataWrite      = $urandom_range(1) == 1;
                dataAddress    = $urandom;
                dataWriteData  = $urandom;
                dataByteEnable = 4'($urandom_range(15));
            end
        end

        go(); reset = 1; idleInputs();
        go(); reset = 0;
        go();
        smp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
